// File: rtl/spy_readout_sequencer.sv
// Dumps a frozen spy buffer (metadata list, then spy memory, each oldest first) over one
// valid/ready stream through a 2-entry skid FIFO fed by 1-cycle-latency read ports.
module spy_readout_sequencer #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned SPY_MEM_WIDTH = 7,
  parameter int unsigned EL_MEM_WIDTH  = 4,
  parameter int unsigned FREEZE_SETTLE = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     freeze_o,
  input  logic [SPY_MEM_WIDTH-1:0] spy_write_addr_i,
  input  logic [EL_MEM_WIDTH-1:0]  spy_meta_write_addr_i,
  output logic                     spy_read_enable_o,
  output logic [SPY_MEM_WIDTH-1:0] spy_read_addr_o,
  output logic                     spy_meta_read_enable_o,
  output logic [EL_MEM_WIDTH-1:0]  spy_meta_read_addr_o,
  input  logic [DATA_WIDTH:0]      spy_data_i,
  input  logic [SPY_MEM_WIDTH:0]   spy_meta_read_data_i,
  output logic [DATA_WIDTH:0]      out_data_o,
  output logic                     out_is_meta_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int unsigned SettleW = (FREEZE_SETTLE > 1) ? $clog2(FREEZE_SETTLE) : 1;
  localparam logic [SettleW-1:0]     SettleLast = SettleW'(FREEZE_SETTLE - 1);
  localparam logic [EL_MEM_WIDTH:0]  MetaLast   = {1'b0, {EL_MEM_WIDTH{1'b1}}};
  localparam logic [SPY_MEM_WIDTH:0] DataLast   = {1'b0, {SPY_MEM_WIDTH{1'b1}}};

  typedef enum logic [2:0] {StIdle, StFreeze, StMeta, StData, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [SettleW-1:0]       settle_q, settle_d;
  logic [SPY_MEM_WIDTH-1:0] base_spy_q, base_spy_d;
  logic [EL_MEM_WIDTH-1:0]  base_meta_q, base_meta_d;
  logic [EL_MEM_WIDTH:0]    meta_cnt_q, meta_cnt_d;
  logic [SPY_MEM_WIDTH:0]   data_cnt_q, data_cnt_d;
  logic                     freeze_q, freeze_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ret_valid_q, ret_valid_d;
  logic                     ret_meta_q, ret_meta_d;

  logic [1:0][DATA_WIDTH:0] fifo_data_q, fifo_data_d;
  logic [1:0]               fifo_meta_q, fifo_meta_d;
  logic                     fifo_rd_q, fifo_rd_d;
  logic                     fifo_wr_q, fifo_wr_d;
  logic [1:0]               fifo_cnt_q, fifo_cnt_d;

  logic                     pop;
  logic                     flush;
  logic [2:0]               pending;
  logic                     can_issue;
  logic                     meta_issue;
  logic                     data_issue;
  logic [DATA_WIDTH:0]      meta_ext;
  logic [DATA_WIDTH:0]      push_word;

  assign flush = abort_i && (state_q != StIdle);
  assign pop   = (fifo_cnt_q != 2'd0) && out_ready_i;

  // Slots already claimed once this cycle's transfer frees one; a new read needs one left.
  assign pending    = {1'b0, fifo_cnt_q} + {2'b00, ret_valid_q} - {2'b00, pop};
  assign can_issue  = (pending < 3'd2) && !abort_i;
  assign meta_issue = (state_q == StMeta) && can_issue;
  assign data_issue = (state_q == StData) && can_issue;

  assign spy_meta_read_enable_o = meta_issue;
  assign spy_meta_read_addr_o   = base_meta_q + meta_cnt_q[EL_MEM_WIDTH-1:0];
  assign spy_read_enable_o      = data_issue;
  assign spy_read_addr_o        = base_spy_q + data_cnt_q[SPY_MEM_WIDTH-1:0];

  assign out_valid_o   = (fifo_cnt_q != 2'd0);
  assign out_data_o    = fifo_data_q[fifo_rd_q];
  assign out_is_meta_o = fifo_meta_q[fifo_rd_q];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign freeze_o      = freeze_q;

  always_comb begin
    meta_ext = '0;
    meta_ext[SPY_MEM_WIDTH:0] = spy_meta_read_data_i;
    push_word = ret_meta_q ? meta_ext : spy_data_i;
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    base_spy_d  = base_spy_q;
    base_meta_d = base_meta_q;
    meta_cnt_d  = meta_cnt_q;
    data_cnt_d  = data_cnt_q;
    freeze_d    = freeze_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ret_valid_d = meta_issue || data_issue;
    ret_meta_d  = meta_issue;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d  = StFreeze;
          settle_d = '0;
          freeze_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StFreeze: begin
        if (settle_q == SettleLast) begin
          base_spy_d  = spy_write_addr_i;
          base_meta_d = spy_meta_write_addr_i;
          meta_cnt_d  = '0;
          state_d     = StMeta;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StMeta: begin
        if (meta_issue) begin
          meta_cnt_d = meta_cnt_q + 1'b1;
          if (meta_cnt_q == MetaLast) begin
            data_cnt_d = '0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (data_issue) begin
          data_cnt_d = data_cnt_q + 1'b1;
          if (data_cnt_q == DataLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!ret_valid_q && (fifo_cnt_q == 2'd0)) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          freeze_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d     = StIdle;
      freeze_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      ret_valid_d = 1'b0;
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_meta_d = fifo_meta_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, ret_valid_q} - {1'b0, pop};
    if (ret_valid_q) begin
      fifo_data_d[fifo_wr_q] = push_word;
      fifo_meta_d[fifo_wr_q] = ret_meta_q;
      fifo_wr_d              = ~fifo_wr_q;
    end
    if (pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    // Abort drops the queued words and the return arriving this cycle.
    if (flush) begin
      fifo_cnt_d = '0;
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      base_spy_q  <= '0;
      base_meta_q <= '0;
      meta_cnt_q  <= '0;
      data_cnt_q  <= '0;
      freeze_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_meta_q  <= 1'b0;
      fifo_data_q <= '0;
      fifo_meta_q <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      base_spy_q  <= base_spy_d;
      base_meta_q <= base_meta_d;
      meta_cnt_q  <= meta_cnt_d;
      data_cnt_q  <= data_cnt_d;
      freeze_q    <= freeze_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ret_valid_q <= ret_valid_d;
      ret_meta_q  <= ret_meta_d;
      fifo_data_q <= fifo_data_d;
      fifo_meta_q <= fifo_meta_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_spy_readout_sequencer.sv
// Bench for spy_readout_sequencer: memory models, stream monitor and a queue-based
// model of the expected dump, driven with randomized contents, pointers and backpressure.
module tb_spy_readout_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 3;
  localparam int unsigned EW = 2;
  localparam int unsigned FS = 2;
  localparam int unsigned NM = 4;
  localparam int unsigned ND = 8;
  localparam int unsigned NW = NM + ND;
  localparam int unsigned WW = DW + 1;
  localparam int unsigned MW = SW + 1;

  logic clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic busy, done, freeze, spy_re, meta_re, out_is_meta, out_valid;
  logic [SW-1:0] spy_wa = '0, spy_ra;
  logic [EW-1:0] meta_wa = '0, meta_ra;
  logic [DW:0]   spy_data = '0, out_data;
  logic [SW:0]   meta_data = '0;
  logic [DW:0]   spy_mem [ND];
  logic [SW:0]   meta_mem [NM];

  int n_cmp = 0, n_bad = 0;
  int rdy_mode = 0;
  logic [DW+1:0] exp_q[$];

  // Monitor-owned state
  logic [DW+1:0] got_q[$];
  int spy_addrs[$], meta_addrs[$];
  int cyc = 0, done_cnt = 0, onehot_bad = 0, stall_bad = 0, done_frz_bad = 0;
  int outst = 0, max_outst = 0, rd_cyc = 0, lat = 0, frz_pre = 0;
  int xfer_first = 0, xfer_last = 0, xfers_dump = 0, xfers_at_done = 0;
  bit seen_rd = 0, seen_val = 0;
  logic frz_prev = 1'b0, stall_prev = 1'b0;
  logic [DW+1:0] word_prev = '0;

  spy_readout_sequencer #(
    .DATA_WIDTH(DW), .SPY_MEM_WIDTH(SW), .EL_MEM_WIDTH(EW), .FREEZE_SETTLE(FS)
  ) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .freeze_o(freeze),
    .spy_write_addr_i(spy_wa), .spy_meta_write_addr_i(meta_wa),
    .spy_read_enable_o(spy_re), .spy_read_addr_o(spy_ra),
    .spy_meta_read_enable_o(meta_re), .spy_meta_read_addr_o(meta_ra),
    .spy_data_i(spy_data), .spy_meta_read_data_i(meta_data),
    .out_data_o(out_data), .out_is_meta_o(out_is_meta), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) begin
    if (spy_re) spy_data <= spy_mem[spy_ra];
    if (meta_re) meta_data <= meta_mem[meta_ra];
  end

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (freeze && !frz_prev) begin
      seen_rd = 0; seen_val = 0; frz_pre = 0; outst = 0; xfers_dump = 0;
    end
    if (freeze && !seen_rd && !spy_re && !meta_re) frz_pre++;
    if ((spy_re || meta_re) && !seen_rd) begin seen_rd = 1; rd_cyc = cyc; end
    if (out_valid && seen_rd && !seen_val) begin seen_val = 1; lat = cyc - rd_cyc; end
    if (spy_re && meta_re) onehot_bad++;
    if (spy_re) spy_addrs.push_back(int'(spy_ra));
    if (meta_re) meta_addrs.push_back(int'(meta_ra));
    if (spy_re || meta_re) outst++;
    if (out_valid && out_ready) begin
      got_q.push_back({out_is_meta, out_data});
      outst--;
      if (xfers_dump == 0) xfer_first = cyc;
      xfer_last = cyc;
      xfers_dump++;
    end
    if (outst > max_outst) max_outst = outst;
    if (stall_prev && (!out_valid || {out_is_meta, out_data} !== word_prev)) stall_bad++;
    stall_prev = out_valid && !out_ready;
    word_prev  = {out_is_meta, out_data};
    if (done) begin
      done_cnt++;
      xfers_at_done = xfers_dump;
      if (freeze || !frz_prev) done_frz_bad++;
    end
    frz_prev = freeze;
  end

  // Model: metadata oldest-first from the meta pointer, then spy words from the spy pointer.
  function automatic void build_exp(input int sp, input int mp);
    exp_q.delete();
    for (int k = 0; k < int'(NM); k++)
      exp_q.push_back({1'b1, {(DW - SW){1'b0}}, meta_mem[(mp + k) % NM]});
    for (int k = 0; k < int'(ND); k++)
      exp_q.push_back({1'b0, spy_mem[(sp + k) % ND]});
  endfunction

  task automatic load(input int sp, input int mp);
    for (int i = 0; i < int'(ND); i++) spy_mem[i] = WW'($urandom);
    for (int i = 0; i < int'(NM); i++) meta_mem[i] = MW'($urandom);
    spy_wa  = SW'(sp);
    meta_wa = EW'(mp);
    build_exp(sp, mp);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int snap_d, output bit to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #1;
      if (done_cnt != snap_d) begin to = 0; break; end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({busy, done, freeze, spy_re, meta_re, out_valid, out_is_meta} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, freeze, spy_re, meta_re,
               out_valid, out_is_meta});
    end
    n_cmp++;
    if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
    n_cmp++;
    if ({spy_ra, meta_ra} !== '0) begin
      n_bad++; $display("FAIL reset_addr: got %0h want 0", {spy_ra, meta_ra});
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_full_dump();
    int sg, ss, sm, sd;
    bit to;
    rdy_mode = 0;
    load(5, 1);
    sg = got_q.size(); ss = spy_addrs.size(); sm = meta_addrs.size(); sd = done_cnt;
    pulse_start();
    wait_done(sd, to);
    repeat (5) @(negedge clock);
    #1;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL full_timeout: got no done want done"); end
    n_cmp++;
    if (done_cnt - sd != 1) begin n_bad++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - sd); end
    n_cmp++;
    if (meta_addrs.size() - sm != int'(NM) || spy_addrs.size() - ss != int'(ND)) begin
      n_bad++; $display("FAIL full_read_cnt: got %0d/%0d want 4/8", meta_addrs.size() - sm,
                        spy_addrs.size() - ss);
    end
    for (int k = 0; k < int'(NM); k++) begin
      n_cmp++;
      if (sm + k >= meta_addrs.size() || meta_addrs[sm + k] != (1 + k) % int'(NM)) begin
        n_bad++; $display("FAIL full_meta_addr[%0d]: got %0d want %0d", k,
                          (sm + k < meta_addrs.size()) ? meta_addrs[sm + k] : -1, (1 + k) % NM);
      end
    end
    for (int k = 0; k < int'(ND); k++) begin
      n_cmp++;
      if (ss + k >= spy_addrs.size() || spy_addrs[ss + k] != (5 + k) % int'(ND)) begin
        n_bad++; $display("FAIL full_spy_addr[%0d]: got %0d want %0d", k,
                          (ss + k < spy_addrs.size()) ? spy_addrs[ss + k] : -1, (5 + k) % ND);
      end
    end
    n_cmp++;
    if (got_q.size() - sg != int'(NW)) begin
      n_bad++; $display("FAIL full_xfer_cnt: got %0d want %0d", got_q.size() - sg, NW);
    end
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (sg + k >= got_q.size() || got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL full_word[%0d]: got %0h want %0h", k,
                          (sg + k < got_q.size()) ? got_q[sg + k] : '0, exp_q[k]);
      end
    end
    n_cmp++;
    if (frz_pre != int'(FS)) begin n_bad++; $display("FAIL full_settle: got %0d want %0d", frz_pre, FS); end
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL full_latency: got %0d want 2", lat); end
    n_cmp++;
    if (xfer_last - xfer_first != int'(NW) - 1) begin
      n_bad++; $display("FAIL full_throughput: got %0d want %0d", xfer_last - xfer_first, NW - 1);
    end
    n_cmp++;
    if (done_frz_bad != 0) begin n_bad++; $display("FAIL full_done_freeze: got %0d want 0", done_frz_bad); end
  endtask

  task automatic test_backpressure();
    int sg, sd, sst, sp, mp;
    bit to;
    sp = $urandom_range(0, ND - 1);
    mp = $urandom_range(0, NM - 1);
    load(sp, mp);
    rdy_mode = 1;
    sg = got_q.size(); sd = done_cnt; sst = stall_bad;
    pulse_start();
    wait_done(sd, to);
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); end
    n_cmp++;
    if (got_q.size() - sg != int'(NW)) begin
      n_bad++; $display("FAIL bp_xfer_cnt: got %0d want %0d", got_q.size() - sg, NW);
    end
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (sg + k >= got_q.size() || got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL bp_word[%0d]: got %0h want %0h", k,
                          (sg + k < got_q.size()) ? got_q[sg + k] : '0, exp_q[k]);
      end
    end
    n_cmp++;
    if (stall_bad != sst) begin n_bad++; $display("FAIL bp_stable: got %0d want 0", stall_bad - sst); end
    n_cmp++;
    if (max_outst > 2) begin n_bad++; $display("FAIL bp_outstanding: got %0d want <=2", max_outst); end
    n_cmp++;
    if (xfers_at_done != int'(NW)) begin
      n_bad++; $display("FAIL bp_done_after_last: got %0d want %0d", xfers_at_done, NW);
    end
    n_cmp++;
    if (onehot_bad != 0) begin n_bad++; $display("FAIL bp_onehot: got %0d want 0", onehot_bad); end
  endtask

  task automatic test_abort();
    int sg, sd, n;
    bit to, reached;
    load($urandom_range(0, ND - 1), $urandom_range(0, NM - 1));
    sg = got_q.size();
    pulse_start();
    reached = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (got_q.size() - sg >= int'(NM) + 3) begin reached = 1; break; end
    end
    n_cmp++;
    if (!reached) begin n_bad++; $display("FAIL abort_reach: got %0d xfers want 7", got_q.size() - sg); end
    sd = done_cnt;
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    n_cmp++;
    if ({busy, freeze, out_valid, spy_re, meta_re} !== 5'b0) begin
      n_bad++; $display("FAIL abort_outputs: got %b want 0", {busy, freeze, out_valid, spy_re, meta_re});
    end
    repeat (10) @(negedge clock);
    #1;
    n_cmp++;
    if (done_cnt != sd) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - sd); end
    n = got_q.size() - sg;
    for (int k = 0; k < n && k < int'(NW); k++) begin
      n_cmp++;
      if (got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL abort_prefix[%0d]: got %0h want %0h", k, got_q[sg + k], exp_q[k]);
      end
    end
    load($urandom_range(0, ND - 1), $urandom_range(0, NM - 1));
    sg = got_q.size(); sd = done_cnt;
    pulse_start();
    wait_done(sd, to);
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if (to || got_q.size() - sg != int'(NW)) begin
      n_bad++; $display("FAIL abort_redump_cnt: got %0d want %0d", got_q.size() - sg, NW);
    end
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (sg + k >= got_q.size() || got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL abort_redump[%0d]: got %0h want %0h", k,
                          (sg + k < got_q.size()) ? got_q[sg + k] : '0, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_meta();
    int sm, sg, sd;
    bit to, reached;
    load($urandom_range(0, ND - 1), $urandom_range(0, NM - 1));
    sm = meta_addrs.size();
    pulse_start();
    reached = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #1;
      if (meta_addrs.size() > sm) begin reached = 1; break; end
    end
    n_cmp++;
    if (!reached || !meta_re) begin n_bad++; $display("FAIL rst_reach_meta: got %b want 1", meta_re); end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, freeze, spy_re, meta_re, out_valid, out_is_meta} !== 7'b0 ||
        out_data !== '0 || {spy_ra, meta_ra} !== '0) begin
      n_bad++; $display("FAIL rst_async: got %b/%0h want 0", {busy, done, freeze, spy_re, meta_re,
                        out_valid, out_is_meta}, out_data);
    end
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b want 0", busy); end
    sg = got_q.size(); sd = done_cnt;
    pulse_start();
    wait_done(sd, to);
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if (to || got_q.size() - sg != int'(NW)) begin
      n_bad++; $display("FAIL rst_redump_cnt: got %0d want %0d", got_q.size() - sg, NW);
    end
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (sg + k >= got_q.size() || got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL rst_redump[%0d]: got %0h want %0h", k,
                          (sg + k < got_q.size()) ? got_q[sg + k] : '0, exp_q[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int sm, sg, sd;
    bit to, busy_seen;
    load($urandom_range(0, ND - 1), $urandom_range(0, NM - 1));
    sm = meta_addrs.size(); sg = got_q.size(); sd = done_cnt;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #1;
      if (meta_addrs.size() > sm) break;
    end
    pulse_start();
    wait_done(sd, to);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (busy) busy_seen = 1;
    end
    @(posedge clock); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clock); #1 begin start = 1'b0; abort = 1'b0; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (busy || freeze) busy_seen = 1;
    end
    n_cmp++;
    if (to || done_cnt - sd != 1) begin
      n_bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt - sd);
    end
    n_cmp++;
    if (busy_seen) begin n_bad++; $display("FAIL ign_second_dump: got busy want idle"); end
    n_cmp++;
    if (got_q.size() - sg != int'(NW)) begin
      n_bad++; $display("FAIL ign_xfer_cnt: got %0d want %0d", got_q.size() - sg, NW);
    end
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (sg + k >= got_q.size() || got_q[sg + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL ign_word[%0d]: got %0h want %0h", k,
                          (sg + k < got_q.size()) ? got_q[sg + k] : '0, exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_backpressure();
    test_abort();
    test_reset_mid_meta();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spy_readout_sequencer.md
Name: spy_readout_sequencer

Overview:
- Sequences a complete readout ("dump") of one spy buffer's spy memory and event-metadata list over a single valid/ready stream.
- On `start`, asserts `freeze`, waits for the spy write side to settle and latches both write pointers. It then reads the whole metadata list and the whole spy memory, oldest entry first, and releases `freeze`.
- Sits in the spy buffer's write clock domain and drives its spy read ports, replacing ad-hoc external address generation.

Parameters:
- DATA_WIDTH, 64: spy data payload width; a spy word is DATA_WIDTH+1 bits (includes metadata flag bit).
- SPY_MEM_WIDTH, 7: spy memory address width; depth is 2^SPY_MEM_WIDTH.
- EL_MEM_WIDTH, 4: metadata list address width; depth is 2^EL_MEM_WIDTH.
- FREEZE_SETTLE, 2: cycles `freeze` is held before pointers are latched; must be ≥1.

Ports:
- clock  in  1  single clock (spy buffer write clock).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; requests a dump; honoured only in IDLE.
- abort  in  1  level/pulse; cancels a dump in progress.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a dump completes normally.
- freeze  out  1  to spy buffer `freeze`.
- spy_write_addr  in  SPY_MEM_WIDTH  spy memory write pointer; points at the oldest entry.
- spy_meta_write_addr  in  EL_MEM_WIDTH  metadata write pointer; points at the oldest entry.
- spy_read_enable  out  1  spy memory read strobe.
- spy_read_addr  out  SPY_MEM_WIDTH  spy memory read address.
- spy_meta_read_enable  out  1  metadata read strobe.
- spy_meta_read_addr  out  EL_MEM_WIDTH  metadata read address.
- spy_data  in  DATA_WIDTH+1  spy memory read data, valid 1 cycle after the strobe.
- spy_meta_read_data  in  SPY_MEM_WIDTH+1  metadata read data, valid 1 cycle after the strobe.
- out_data  out  DATA_WIDTH+1  stream payload; metadata words are zero-extended.
- out_is_meta  out  1  high when `out_data` carries a metadata entry.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when `out_valid` and `out_ready` are both high.

Behaviour:
- Reset values (asynchronous): state IDLE; every output 0; counters, latched pointers, skid FIFO and in-flight flag cleared.
- States:
  - IDLE: `start` moves to FREEZE.
  - FREEZE: `freeze` asserts from the first FREEZE cycle through DRAIN inclusive. The settle counter runs FREEZE_SETTLE cycles. On the last cycle, `spy_write_addr` and `spy_meta_write_addr` are latched as the base pointers; go to META.
  - META: issue 2^EL_MEM_WIDTH metadata reads at base_meta+k (mod 2^EL_MEM_WIDTH), k=0..N-1; go to DATA on the cycle the last read issues.
  - DATA: issue 2^SPY_MEM_WIDTH spy reads at base_spy+k (mod 2^SPY_MEM_WIDTH); go to DRAIN after the last read issues.
  - DRAIN: wait until nothing is in flight and the skid FIFO is empty. Then pulse `done`, drop `freeze` and return to IDLE, all on the same edge.
- Issue counters are SPY_MEM_WIDTH+1 and EL_MEM_WIDTH+1 bits wide. Addresses wrap naturally by truncation.
- Read pipeline: fixed 1-cycle memory latency. Returned data is captured into a 2-entry skid FIFO, tagged meta or data. `out_*` is the FIFO head.
- Issue rule: a read issues in a cycle only if (FIFO occupancy + in-flight count) < 2, counting a transfer on the same cycle as freeing a slot. This guarantees no overflow under arbitrary `out_ready`.
- Throughput: with `out_ready` held high, one word per cycle after the pipeline fills. The first `out_valid` appears 2 cycles after the first read strobe.
- Ordering: all metadata words precede all data words. Within each group, oldest first. No word is dropped or duplicated.
- Read strobes are one-hot: `spy_read_enable` and `spy_meta_read_enable` are never high together. Both are low outside META/DATA.
- `out_data` and `out_is_meta` are held stable while `out_valid` is high and `out_ready` is low.
- `start` while busy is ignored; it is not queued.
- Abort: `abort` in any non-IDLE state takes effect on the next edge:
  - state → IDLE; `freeze` → 0; read strobes → 0;
  - skid FIFO flushed; any in-flight return discarded;
  - `out_valid` → 0; no `done` pulse.
- `start` and `abort` together in IDLE: abort wins; stay IDLE.
- Reset mid-dump: identical to reset values; `freeze` drops asynchronously.

Test Plan:
- Full dump, parameters 3/2, FREEZE_SETTLE=2, `out_ready`=1, pointers spy=5, meta=1: `freeze` high 2 cycles, then meta reads at addr 1,2,3,0, then spy reads at 5,6,7,0,1,2,3,4. Exactly 12 transfers: 4 with `out_is_meta`=1 followed by 8 data words matching memory contents. `done` pulses once and `freeze` falls on the same edge.
- Backpressure: `out_ready` toggles in a pseudo-random pattern → identical 12-word sequence; `out_data` stable while stalled; never more than 2 reads outstanding; `done` only after the last transfer.
- Abort during DATA after 3 data transfers: next cycle `busy`=0, `freeze`=0, `out_valid`=0, no `done`. A following `start` performs a complete 12-word dump.
- Reset asserted mid-META: all outputs 0 immediately, without waiting for a clock edge. After release, the block is idle and accepts `start`.
- `start` pulsed during META, and `start`+`abort` together in IDLE: the first dump completes unaffected, no second dump occurs, and the block stays IDLE.
